// File: rtl/mcp_capture_pkg.sv
// ---------------------------------------------------------------------------
// mcp_capture_pkg
//   Shared types and helpers for the multi-cycle-path capture stage.
//   - mcp_state_t : capture FSM states (IDLE / WAIT / HOLD)
//   - MCP_CNT_W   : width of the launch-to-capture countdown
//   - ERR_CNT_W   : width of the saturating error counter
//   - sat_inc()   : saturating increment used by the error counter
// ---------------------------------------------------------------------------
package mcp_capture_pkg;

  // IDLE: nothing pending, WAIT: counting down to the capture edge,
  // HOLD: data captured, watching the bus for late movement
  typedef enum logic [1:0] {
    MCP_IDLE = 2'd0,
    MCP_WAIT = 2'd1,
    MCP_HOLD = 2'd2
  } mcp_state_t;

  localparam int MCP_CNT_W = 8;
  localparam int ERR_CNT_W = 16;

  // Adds one when inc is set, but sticks at all-ones instead of wrapping
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] count,
                                                   input logic                 inc);
    logic [ERR_CNT_W-1:0] result;
    result = count;
    if (inc && (count != {ERR_CNT_W{1'b1}})) begin
      result = count + ERR_CNT_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/mcp_sat_counter.sv
// ---------------------------------------------------------------------------
// mcp_sat_counter
//   ERR_CNT_W-bit event counter that saturates at all-ones and never wraps.
// Ports
//   clk   in   1          clock, posedge
//   rst   in   1          synchronous reset, active-high, clears the count
//   inc   in   1          count one event this cycle
//   count out  ERR_CNT_W  current (saturated) count
// ---------------------------------------------------------------------------
module mcp_sat_counter
  import mcp_capture_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [ERR_CNT_W-1:0] count
);

  // Count register; reset wins over any pending increment
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= sat_inc(count, inc);
    end
  end

endmodule

// File: rtl/mcp_capture_reg.sv
// ---------------------------------------------------------------------------
// mcp_capture_reg
//   Destination-side capture stage for a multi-cycle path. A source launch
//   pulse starts a countdown of MCP_CYCLES clocks; on the final edge the bus
//   is registered into data_out and dst_valid pulses. After a capture the
//   stage keeps comparing the bus against the captured value and flags any
//   movement that happens without a new launch (late data). A launch that
//   arrives while a capture is still pending restarts the countdown and is
//   flagged as an overrun. Both error kinds feed a saturating counter.
//
// Parameters
//   BUS_WIDTH   width of the captured bus
//   MCP_CYCLES  launch-to-capture distance in clocks, 1..255
//
// Ports
//   clk          in   1          clock, all logic on posedge
//   rst          in   1          synchronous reset, active-high
//   src_launch   in   1          1-cycle launch pulse from the source side
//   data_in      in   BUS_WIDTH  multi-cycle bus (after the delay model)
//   data_out     out  BUS_WIDTH  captured data register
//   dst_valid    out  1          1-cycle pulse: data_out updated
//   busy         out  1          capture pending (state WAIT)
//   late_err     out  1          1-cycle pulse: bus moved after capture
//   overrun_err  out  1          1-cycle pulse: launch while capture pending
//   err_count    out  16         saturating count of error pulses
//
// Configuration
//   MCP_CAPTURE_XCHECK_EN : when defined, an X/Z on data_in at the capture
//   edge raises a simulation $error and bumps err_count. Capture still
//   takes the X value. When undefined, no X check is built.
// ---------------------------------------------------------------------------
module mcp_capture_reg
  import mcp_capture_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int MCP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_launch,
  input  logic [BUS_WIDTH-1:0] data_in,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 dst_valid,
  output logic                 busy,
  output logic                 late_err,
  output logic                 overrun_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // The countdown register is only MCP_CNT_W bits wide, so larger distances
  // cannot be represented; zero would mean capturing on the launch edge.
  generate
    if ((MCP_CYCLES < 1) || (MCP_CYCLES > 255)) begin : g_bad_mcp_cycles
      $fatal(1, "mcp_capture_reg: MCP_CYCLES=%0d outside legal range 1..255", MCP_CYCLES);
    end
  endgenerate

  // Counter value loaded on a launch: the capture happens when it reaches 0,
  // which is exactly MCP_CYCLES edges after the launch edge.
  localparam logic [MCP_CNT_W-1:0] CNT_RELOAD = MCP_CNT_W'(MCP_CYCLES - 1);

  mcp_state_t           state;
  logic [MCP_CNT_W-1:0] cnt;

  logic capture_now;
  logic overrun_now;
  logic late_now;
  logic xerr_now;
  logic err_inc;

  // Decode this cycle's events from the current state. The error pulses are
  // the registered versions of these, and the error counter counts them on
  // the same edge the pulses are registered. Case-equality is used for the
  // late check so a captured X that stays X is not reported as movement.
  always_comb begin
    capture_now = (state == MCP_WAIT) && (cnt == '0);
    overrun_now = (state == MCP_WAIT) && (cnt != '0) && src_launch;
    late_now    = (state == MCP_HOLD) && !src_launch && (data_in !== data_out);
  end

`ifdef MCP_CAPTURE_XCHECK_EN
  // Simulation-only check: an unknown bit on the bus at the capture edge
  // means the path was not settled in time.
  assign xerr_now = capture_now && ((^data_in) === 1'bx);

  always @(posedge clk) begin
    if (!rst && xerr_now) begin
      $error("%m: X/Z on data_in at capture edge, time %0t", $time);
    end
  end
`else
  assign xerr_now = 1'b0;
`endif

  // Late and overrun are mutually exclusive by state, and an X event can
  // only occur on a capture edge, so at most one increment per edge.
  assign err_inc = late_now | overrun_now | xerr_now;

  assign busy = (state == MCP_WAIT);

  // Capture FSM with registered pulse outputs. Pulses default to zero every
  // cycle. A launch on the capture edge itself is a legal back-to-back
  // transfer: the capture completes and the countdown restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MCP_IDLE;
      cnt         <= '0;
      data_out    <= '0;
      dst_valid   <= 1'b0;
      late_err    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      dst_valid   <= 1'b0;
      late_err    <= late_now;
      overrun_err <= overrun_now;

      case (state)
        MCP_IDLE: begin
          if (src_launch) begin
            state <= MCP_WAIT;
            cnt   <= CNT_RELOAD;
          end
        end

        MCP_WAIT: begin
          if (cnt != '0) begin
            if (src_launch) begin
              cnt <= CNT_RELOAD;
            end else begin
              cnt <= cnt - MCP_CNT_W'(1);
            end
          end else begin
            data_out  <= data_in;
            dst_valid <= 1'b1;
            if (src_launch) begin
              state <= MCP_WAIT;
              cnt   <= CNT_RELOAD;
            end else begin
              state <= MCP_HOLD;
            end
          end
        end

        MCP_HOLD: begin
          if (src_launch) begin
            state <= MCP_WAIT;
            cnt   <= CNT_RELOAD;
          end
        end

        default: begin
          state <= MCP_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating count of all error pulses
  mcp_sat_counter u_err_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule

// File: tb/tb_mcp_capture_reg.sv
// ---------------------------------------------------------------------------
// tb_mcp_capture_reg
//   Self-checking bench for mcp_capture_reg. Three instances cover the
//   launch-to-capture distances 2, 3 and 1. Expected captures are queued
//   when a launch is driven and compared when dst_valid appears.
// ---------------------------------------------------------------------------
module tb_mcp_capture_reg;

  typedef struct {
    logic [31:0] data;
    int          edge_num;
  } exp_t;

  logic clk;
  logic rst;

  logic        launch1, launch2, launch3;
  logic [31:0] data_in1, data_in2, data_in3;
  logic [31:0] data_out1, data_out2, data_out3;
  logic        dst_valid1, dst_valid2, dst_valid3;
  logic        busy1, busy2, busy3;
  logic        late_err1, late_err2, late_err3;
  logic        overrun_err1, overrun_err2, overrun_err3;
  logic [15:0] err_count1, err_count2, err_count3;

  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  int edge_num = 0;
  int checks   = 0;
  int failures = 0;

  mcp_capture_reg #(.BUS_WIDTH(32), .MCP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .src_launch(launch1), .data_in(data_in1),
    .data_out(data_out1), .dst_valid(dst_valid1), .busy(busy1),
    .late_err(late_err1), .overrun_err(overrun_err1), .err_count(err_count1)
  );

  mcp_capture_reg #(.BUS_WIDTH(32), .MCP_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .src_launch(launch2), .data_in(data_in2),
    .data_out(data_out2), .dst_valid(dst_valid2), .busy(busy2),
    .late_err(late_err2), .overrun_err(overrun_err2), .err_count(err_count2)
  );

  mcp_capture_reg #(.BUS_WIDTH(32), .MCP_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .src_launch(launch3), .data_in(data_in3),
    .data_out(data_out3), .dst_valid(dst_valid3), .busy(busy3),
    .late_err(late_err3), .overrun_err(overrun_err3), .err_count(err_count3)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far; used to time-stamp expected captures
  always @(posedge clk) edge_num <= edge_num + 1;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h @%0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one instance's launch and bus for the next edge
  task automatic applyStimulus(input int id, input logic launch, input logic [31:0] data);
    case (id)
      1: begin launch1 = launch; data_in1 = data; end
      2: begin launch2 = launch; data_in2 = data; end
      3: begin launch3 = launch; data_in3 = data; end
      default: ;
    endcase
  endtask

  // Queue a capture the given instance must produce at edge exp_edge
  task automatic expectCapture(input int id, input logic [31:0] data, input int exp_edge);
    exp_t e;
    e.data     = data;
    e.edge_num = exp_edge;
    case (id)
      1: q1.push_back(e);
      2: q2.push_back(e);
      3: q3.push_back(e);
      default: ;
    endcase
  endtask

  // Compare one instance's capture output with the head of its queue. An
  // expectation whose edge has passed without dst_valid is reported as a
  // miss; dst_valid with nothing queued is reported as unexpected.
  task automatic scoreDut(input int id, input logic dv, input logic [31:0] dout);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (id)
      1: if (q1.size() != 0) begin e = q1[0]; have = 1'b1; end
      2: if (q2.size() != 0) begin e = q2[0]; have = 1'b1; end
      3: if (q3.size() != 0) begin e = q3[0]; have = 1'b1; end
      default: ;
    endcase
    if (have && (dv || (e.edge_num <= edge_num))) begin
      case (id)
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        3: e = q3.pop_front();
        default: ;
      endcase
      checkOutput($sformatf("dut%0d_valid", id), {31'b0, dv}, 32'd1);
      checkOutput($sformatf("dut%0d_capture_edge", id), 32'(edge_num), 32'(e.edge_num));
      checkOutput($sformatf("dut%0d_data_out", id), dout, e.data);
    end else if (dv) begin
      checkOutput($sformatf("dut%0d_unexpected_valid", id), {31'b0, dv}, 32'd0);
    end
  endtask

  // Scoreboard monitor, sampled half a cycle away from the active edge
  always @(negedge clk) begin
    scoreDut(1, dst_valid1, data_out1);
    scoreDut(2, dst_valid2, data_out2);
    scoreDut(3, dst_valid3, data_out3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard time limit so the bench always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1, 1'b0, 32'h0);
    applyStimulus(2, 1'b0, 32'h0);
    applyStimulus(3, 1'b0, 32'h0);
    repeat (2) tick();

    // Reset state
    checkOutput("rst_data_out2", data_out2, 32'h0);
    checkOutput("rst_dst_valid2", {31'b0, dst_valid2}, 32'd0);
    checkOutput("rst_busy2", {31'b0, busy2}, 32'd0);
    checkOutput("rst_err_count2", {16'b0, err_count2}, 32'd0);
    checkOutput("rst_late2", {31'b0, late_err2}, 32'd0);
    checkOutput("rst_overrun2", {31'b0, overrun_err2}, 32'd0);
    checkOutput("rst_busy1", {31'b0, busy1}, 32'd0);
    checkOutput("rst_busy3", {31'b0, busy3}, 32'd0);
    rst = 1'b0;
    tick();

    // T1: distance 2, bus settles one cycle after the launch
    $display("[TB] T1 single capture, MCP_CYCLES=2");
    applyStimulus(2, 1'b1, 32'hDEAD_0000);
    expectCapture(2, 32'hA5A5_0001, edge_num + 3);
    tick();
    checkOutput("t1_busy_after_launch", {31'b0, busy2}, 32'd1);
    applyStimulus(2, 1'b0, 32'hA5A5_0001);
    tick();
    checkOutput("t1_busy_waiting", {31'b0, busy2}, 32'd1);
    checkOutput("t1_no_early_valid", {31'b0, dst_valid2}, 32'd0);
    tick();
    checkOutput("t1_valid_at_capture", {31'b0, dst_valid2}, 32'd1);
    checkOutput("t1_busy_after_capture", {31'b0, busy2}, 32'd0);
    tick();
    checkOutput("t1_valid_one_cycle", {31'b0, dst_valid2}, 32'd0);
    checkOutput("t1_no_late", {31'b0, late_err2}, 32'd0);
    checkOutput("t1_err_count", {16'b0, err_count2}, 32'd0);

    // T3: capture 1, bus moves to 2 without a launch, then saturate the count
    $display("[TB] T3 late data and counter saturation");
    applyStimulus(2, 1'b1, 32'h1);
    expectCapture(2, 32'h1, edge_num + 3);
    tick();
    applyStimulus(2, 1'b0, 32'h1);
    repeat (2) tick();
    tick();
    checkOutput("t3_stable_no_late", {31'b0, late_err2}, 32'd0);
    applyStimulus(2, 1'b0, 32'h2);
    tick();
    checkOutput("t3_late_first", {31'b0, late_err2}, 32'd1);
    checkOutput("t3_err_count_1", {16'b0, err_count2}, 32'd1);
    checkOutput("t3_data_out_kept", data_out2, 32'h1);
    tick();
    checkOutput("t3_late_second", {31'b0, late_err2}, 32'd1);
    checkOutput("t3_err_count_2", {16'b0, err_count2}, 32'd2);
    repeat (65540) tick();
    checkOutput("t3_err_saturated", {16'b0, err_count2}, 32'h0000_FFFF);
    checkOutput("t3_late_still", {31'b0, late_err2}, 32'd1);
    checkOutput("t3_data_out_still", data_out2, 32'h1);
    applyStimulus(2, 1'b1, 32'h3);
    expectCapture(2, 32'h3, edge_num + 3);
    tick();
    checkOutput("t3_launch_clears_late", {31'b0, late_err2}, 32'd0);
    checkOutput("t3_err_held", {16'b0, err_count2}, 32'h0000_FFFF);
    applyStimulus(2, 1'b0, 32'h3);
    repeat (3) tick();
    checkOutput("t3_err_no_wrap", {16'b0, err_count2}, 32'h0000_FFFF);

    // T5: reset while the countdown is at 1 cancels the capture
    $display("[TB] T5 reset during WAIT");
    applyStimulus(2, 1'b1, 32'h7);
    tick();
    checkOutput("t5_busy_before_reset", {31'b0, busy2}, 32'd1);
    applyStimulus(2, 1'b0, 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_busy", {31'b0, busy2}, 32'd0);
    checkOutput("t5_dst_valid", {31'b0, dst_valid2}, 32'd0);
    checkOutput("t5_data_out", data_out2, 32'h0);
    checkOutput("t5_err_count", {16'b0, err_count2}, 32'd0);
    checkOutput("t5_late", {31'b0, late_err2}, 32'd0);
    repeat (3) tick();
    checkOutput("t5_still_idle", {31'b0, busy2}, 32'd0);
    checkOutput("t5_late_after", {31'b0, late_err2}, 32'd0);

    // T2: distance 3, second launch while pending restarts the countdown
    $display("[TB] T2 overrun, MCP_CYCLES=3");
    applyStimulus(3, 1'b1, 32'h11);
    tick();
    applyStimulus(3, 1'b1, 32'h22);
    expectCapture(3, 32'h22, edge_num + 4);
    tick();
    checkOutput("t2_overrun_pulse", {31'b0, overrun_err3}, 32'd1);
    checkOutput("t2_err_count", {16'b0, err_count3}, 32'd1);
    applyStimulus(3, 1'b0, 32'h22);
    tick();
    checkOutput("t2_overrun_one_cycle", {31'b0, overrun_err3}, 32'd0);
    checkOutput("t2_busy", {31'b0, busy3}, 32'd1);
    repeat (2) tick();
    checkOutput("t2_valid", {31'b0, dst_valid3}, 32'd1);
    checkOutput("t2_err_count_final", {16'b0, err_count3}, 32'd1);
    tick();

    // T4: distance 1, launch every cycle; each capture sees the next value
    $display("[TB] T4 back-to-back, MCP_CYCLES=1");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, (i < 9), 32'(i));
      if (i < 9) expectCapture(1, 32'(i + 1), edge_num + 2);
      tick();
      checkOutput($sformatf("t4_valid_%0d", i), {31'b0, dst_valid1}, {31'b0, (i >= 1)});
      checkOutput($sformatf("t4_overrun_%0d", i), {31'b0, overrun_err1}, 32'd0);
    end
    tick();
    checkOutput("t4_valid_end", {31'b0, dst_valid1}, 32'd0);
    checkOutput("t4_late_end", {31'b0, late_err1}, 32'd0);
    checkOutput("t4_err_count", {16'b0, err_count1}, 32'd0);
    checkOutput("t4_data_out_last", data_out1, 32'd9);

    // Every queued capture must have been consumed
    repeat (4) tick();
    checkOutput("sb_drain", 32'(q1.size() + q2.size() + q3.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
